trap_ctrl: RTL and testbench
============================

# trap_ctrl

Parametrised trap controller for the RV32I core: turns N fault request lines into one prioritised trap with registered `mepc`/`mcause`/`mtval`. It raises a one-cycle redirect toward the handler vector and tracks handler residency until `mret`. It sits between the pipeline fault sources (IF/ID/MEM) and the PC-select mux. Unlike the previous generation, it adds per-channel pending latches, a handler FSM, masking of nested traps and a return path.

## Interface
- `XLEN`, 32, datapath width
- `NUM_CAUSES`, 4, number of fault channels; channel 0 has highest priority
- `TVEC_BASE`, 472, handler address of channel 0
- `TVEC_STRIDE`, 8, byte spacing between per-channel handler addresses
- `clk`  in  1  clock
- `rst`  in  1  synchronous, active-high reset
- `cause_req`  in  NUM_CAUSES  level fault requests; the rising edge is the event
- `cause_epc`  in  NUM_CAUSES*XLEN  return PC per channel; slice i = `[i*XLEN +: XLEN]`
- `cause_tval`  in  NUM_CAUSES*XLEN  faulting address/instruction per channel
- `mret`  in  1  handler return strobe
- `trap_valid`  out  1  one-cycle redirect to `mtvec_addr`, plus pipeline flush
- `ret_valid`  out  1  one-cycle redirect to `mepc`
- `mtvec_addr`  out  XLEN  handler address of the current trap
- `mepc`  out  XLEN  captured return PC
- `mcause`  out  CW  cause code = channel index + 1; 0 = none; CW = $clog2(NUM_CAUSES+1)
- `mtval`  out  XLEN  captured trap value
- `in_trap`  out  1  handler active

## Operation
- Edge detect: `edge[i] = cause_req[i] & ~req_d[i]`. `req_d` is registered every cycle.
- Pending latch: `pending <= (pending | edge) & ~grant`. Edges are never lost in any state.
- Selection uses `pending | edge`, through a fixed-priority encoder (lowest index wins).
- FSM states: IDLE, TAKE, HANDLER, RETURN.
- IDLE: if any candidate exists, capture `mepc`, `mtval` and `mcause` from the winning channel. Then clear its pending bit and go to TAKE.
- TAKE: `trap_valid=1` for exactly one cycle; then go to HANDLER.
- HANDLER: `in_trap=1`. New edges only set pending bits; no nesting. On `mret`, go to RETURN.
- RETURN: `ret_valid=1` for one cycle and `in_trap` drops; then go to IDLE. Remaining pending causes are taken from IDLE.
- `mret` outside HANDLER is ignored.
- `mtvec_addr = TVEC_BASE + (mcause-1)*TVEC_STRIDE` when `mcause != 0`, else `TVEC_BASE`. Computed in XLEN-bit arithmetic, wraps modulo 2^XLEN.
- `mcause`, `mepc` and `mtval` hold their value until the next trap is captured; they are not cleared by `mret`.

## Timing
- Reset values: all outputs 0; `mtvec_addr` = `TVEC_BASE`; FSM = IDLE; `pending` = 0; `req_d` = 0. A request held high through reset is therefore seen as an edge on the first cycle after reset.
- Latency: rising edge sampled at clock k → registers captured at k → `trap_valid` high during cycle k+1.
- `mret` sampled at clock m in HANDLER → `ret_valid` high during cycle m+1 → IDLE at m+2. A pending cause can then produce `trap_valid` at m+3 at the earliest.
- Simultaneous edges: the lowest index is taken; the others stay pending and are served in priority order after each return.
- Edge in the same cycle as `mret`: latched into pending.
- Edge on an already-pending channel: merges into that pending bit. The second event is lost, by design.
- Reset asserted mid-handler: returns to IDLE and clears pending on the next clock.

## Configuration
- `TRAP_CTRL_MTVAL_EN`
  - Defined: `mtval` is registered from `cause_tval` at capture.
  - Undefined: the `mtval` register is removed, `mtval` is tied to 0, and `cause_tval` is unused.

## Structure
- Package `trap_pkg`:
  - FSM state enum.
  - Cause-code localparams: MEM_ACCESS=1, ILLEGAL=2, INST_ACCESS=3 for the default channel map.
  - CW function.
- Sub-module `trap_prio_enc`: parametrised fixed-priority encoder. Inputs NUM_CAUSES bits; outputs one-hot grant, index, and any-valid flag.

## Test plan
- Single fault on channel 1, `epc`=0x100, `tval`=0xDEAD → one cycle later `trap_valid`=1, `mcause`=2, `mepc`=0x100, `mtvec_addr`=480, `mtval`=0xDEAD (0 without the macro).
- Channels 0 and 2 rise in the same cycle → `mcause`=1 first. After `mret`: `ret_valid` for one cycle, then `trap_valid` with `mcause`=3 and `mtvec_addr`=488.
- Channel 1 rises during HANDLER → no `trap_valid` until after `mret`; then `mcause`=2 is taken.
- Channel 0 level held high for 10 cycles → exactly one trap is taken; no retrigger after `mret`.
- `mret` pulsed in IDLE → no `ret_valid`, no state change.
- `rst` asserted in HANDLER with pending bits set → next cycle all outputs are at reset values and `in_trap`=0. No trap follows unless a request is still high.

Source files
------------

// File: rtl/trap_pkg.sv
// Shared types for the trap controller: FSM states, default cause codes
// and the cause-code width helper.
package trap_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_TAKE,
    ST_HANDLER,
    ST_RETURN
  } trap_state_e;

  localparam int MEM_ACCESS  = 1;
  localparam int ILLEGAL     = 2;
  localparam int INST_ACCESS = 3;

  function automatic int cw(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/trap_ctrl_if.sv
// Fault-source / trap-redirect bundle between the pipeline and trap_ctrl.
// master = pipeline side, slave = trap controller.
interface trap_ctrl_if
  import trap_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int NUM_CAUSES = 4
);

  localparam int CW = cw(NUM_CAUSES);

  logic [NUM_CAUSES-1:0]      cause_req;
  logic [NUM_CAUSES*XLEN-1:0] cause_epc;
  logic [NUM_CAUSES*XLEN-1:0] cause_tval;
  logic                       mret;
  logic                       trap_valid;
  logic                       ret_valid;
  logic [XLEN-1:0]            mtvec_addr;
  logic [XLEN-1:0]            mepc;
  logic [CW-1:0]              mcause;
  logic [XLEN-1:0]            mtval;
  logic                       in_trap;

  modport master (
    output cause_req, cause_epc, cause_tval, mret,
    input  trap_valid, ret_valid, mtvec_addr,
    input  mepc, mcause, mtval, in_trap
  );

  modport slave (
    input  cause_req, cause_epc, cause_tval, mret,
    output trap_valid, ret_valid, mtvec_addr,
    output mepc, mcause, mtval, in_trap
  );

endinterface

// File: rtl/trap_prio_enc.sv
// Fixed-priority encoder: lowest set index wins.
// Outputs one-hot grant, binary index and an any-valid flag.
module trap_prio_enc #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          valid
);

  always_comb begin
    grant = '0;
    idx   = '0;
    valid = |req;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        grant    = '0;
        grant[i] = 1'b1;
        idx      = IW'(i);
      end
    end
  end

endmodule

// File: rtl/trap_ctrl.sv
// Prioritised trap controller with pending latches and handler FSM.
// Optional TRAP_CTRL_MTVAL_EN keeps a registered mtval; otherwise mtval=0.
module trap_ctrl
  import trap_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int NUM_CAUSES  = 4,
  parameter int TVEC_BASE   = 472,
  parameter int TVEC_STRIDE = 8
) (
  input logic       clk,
  input logic       rst,
  trap_ctrl_if.slave bus
);

  localparam int CW = cw(NUM_CAUSES);
  localparam int IW = (NUM_CAUSES > 1) ? $clog2(NUM_CAUSES) : 1;

  trap_state_e state_q, state_d;

  logic [NUM_CAUSES-1:0] req_d_q, req_d_d;
  logic [NUM_CAUSES-1:0] pending_q, pending_d;
  logic [XLEN-1:0]       mepc_q, mepc_d;
  logic [CW-1:0]         mcause_q, mcause_d;

  logic [NUM_CAUSES-1:0] rise;
  logic [NUM_CAUSES-1:0] cand;
  logic [NUM_CAUSES-1:0] grant;
  logic [IW-1:0]         win_idx;
  logic                  any;
  logic                  capture;
  logic [XLEN-1:0]       win_epc;
  logic [XLEN-1:0]       code_x;
  logic                  trap_valid;
  logic                  ret_valid;
  logic                  in_trap;

  assign rise    = bus.cause_req & ~req_d_q;
  assign cand    = pending_q | rise;
  assign capture = (state_q == ST_IDLE) && any;
  assign win_epc = bus.cause_epc[win_idx*XLEN +: XLEN];

  trap_prio_enc #(
    .N  (NUM_CAUSES),
    .IW (IW)
  ) u_enc (
    .req   (cand),
    .grant (grant),
    .idx   (win_idx),
    .valid (any)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      req_d_q   <= '0;
      pending_q <= '0;
      mepc_q    <= '0;
      mcause_q  <= '0;
    end else begin
      state_q   <= state_d;
      req_d_q   <= req_d_d;
      pending_q <= pending_d;
      mepc_q    <= mepc_d;
      mcause_q  <= mcause_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:    if (any) state_d = ST_TAKE;
      ST_TAKE:    state_d = ST_HANDLER;
      ST_HANDLER: if (bus.mret) state_d = ST_RETURN;
      ST_RETURN:  state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Edges are always folded into pending; only a capture consumes one.
  always_comb begin
    req_d_d   = bus.cause_req;
    pending_d = cand & ~(capture ? grant : '0);
    mepc_d    = mepc_q;
    mcause_d  = mcause_q;
    if (capture) begin
      mepc_d   = win_epc;
      mcause_d = CW'(win_idx) + CW'(1);
    end
  end

  always_comb begin
    trap_valid = 1'b0;
    ret_valid  = 1'b0;
    in_trap    = 1'b0;
    unique case (1'b1)
      (state_q == ST_TAKE):    trap_valid = 1'b1;
      (state_q == ST_HANDLER): in_trap    = 1'b1;
      (state_q == ST_RETURN):  ret_valid  = 1'b1;
      default: ;
    endcase
  end

  assign code_x = XLEN'(mcause_q) - XLEN'(1);

  always_comb begin
    bus.mtvec_addr = XLEN'(TVEC_BASE);
    if (mcause_q != '0)
      bus.mtvec_addr = XLEN'(TVEC_BASE) + code_x * XLEN'(TVEC_STRIDE);
  end

`ifdef TRAP_CTRL_MTVAL_EN
  logic [XLEN-1:0] mtval_q, mtval_d;

  always_comb begin
    mtval_d = mtval_q;
    if (capture)
      mtval_d = bus.cause_tval[win_idx*XLEN +: XLEN];
  end

  always_ff @(posedge clk) begin
    if (rst) mtval_q <= '0;
    else     mtval_q <= mtval_d;
  end

  assign bus.mtval = mtval_q;
`else
  logic unused_tval;
  assign unused_tval = ^bus.cause_tval;
  assign bus.mtval   = '0;
`endif

  assign bus.trap_valid = trap_valid;
  assign bus.ret_valid  = ret_valid;
  assign bus.in_trap    = in_trap;
  assign bus.mepc       = mepc_q;
  assign bus.mcause     = mcause_q;

endmodule

// File: tb/tb_trap_ctrl.sv
// Scoreboard bench for trap_ctrl: directed scenarios then random traffic
// against a behavioural model of the trap/return rules.
module tb_trap_ctrl;
  import trap_pkg::*;

  localparam int XLEN = 32;
  localparam int N    = 4;
  localparam int TB   = 472;
  localparam int TS   = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  trap_ctrl_if #(.XLEN(XLEN), .NUM_CAUSES(N)) bus ();

  trap_ctrl #(
    .XLEN        (XLEN),
    .NUM_CAUSES  (N),
    .TVEC_BASE   (TB),
    .TVEC_STRIDE (TS)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    bit          ret;
    int unsigned cause;
    logic [31:0] epc;
    logic [31:0] tval;
    logic [31:0] tvec;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;
  bit mon_en = 0;

  // Model: mode 0 idle, 1 trap just taken, 2 in handler, 3 returning
  logic [N-1:0] m_prev = '0;
  logic [N-1:0] m_pend = '0;
  int           m_mode = 0;
  int unsigned  m_cause = 0;
  logic [31:0]  m_epc = '0;
  logic [31:0]  m_tval = '0;
  bit           m_rst_chk = 0;

  function automatic logic [31:0] tvec_of(input int unsigned c);
    logic [31:0] r;
    if (c == 0) r = 32'(TB);
    else r = 32'(TB) + 32'((c - 1) * TS);
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic model_step();
    logic [N-1:0] rise, cand;
    int w;
    exp_t e;
    if (rst) begin
      m_prev = '0; m_pend = '0; m_mode = 0;
      m_cause = 0; m_epc = '0; m_tval = '0;
      m_rst_chk = 1;
      return;
    end
    m_rst_chk = 0;
    rise = bus.cause_req & ~m_prev;
    m_prev = bus.cause_req;
    cand = m_pend | rise;
    case (m_mode)
      0: if (cand != '0) begin
        w = 0;
        while (!cand[w]) w++;
        m_cause = w + 1;
        m_epc = bus.cause_epc[w*XLEN +: XLEN];
`ifdef TRAP_CTRL_MTVAL_EN
        m_tval = bus.cause_tval[w*XLEN +: XLEN];
`else
        m_tval = '0;
`endif
        cand[w] = 1'b0;
        m_mode = 1;
        e = '{0, m_cause, m_epc, m_tval, tvec_of(m_cause)};
        q.push_back(e);
      end
      1: m_mode = 2;
      2: if (bus.mret) begin
        m_mode = 3;
        e = '{1, m_cause, m_epc, m_tval, tvec_of(m_cause)};
        q.push_back(e);
      end
      default: m_mode = 0;
    endcase
    m_pend = cand;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      if (bus.trap_valid || bus.ret_valid) begin
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL spurious_pulse: got trap=%0b ret=%0b expected none",
                   bus.trap_valid, bus.ret_valid);
        end else begin
          e = q.pop_front();
          chk("pulse_kind", {30'd0, bus.ret_valid, bus.trap_valid},
              e.ret ? 32'd2 : 32'd1);
          chk("mcause", 32'(bus.mcause), e.cause);
          chk("mepc", bus.mepc, e.epc);
          chk("mtval", bus.mtval, e.tval);
          chk("mtvec_addr", bus.mtvec_addr, e.tvec);
        end
      end else if (q.size() != 0) begin
        e = q.pop_front();
        checks++; errors++;
        $display("FAIL missing_pulse: got none expected %s cause %0d",
                 e.ret ? "ret" : "trap", e.cause);
      end
      chk("in_trap", 32'(bus.in_trap), 32'(m_mode == 2));
      chk("mcause_hold", 32'(bus.mcause), m_cause);
      if (m_rst_chk) begin
        chk("rst_mepc", bus.mepc, 32'd0);
        chk("rst_mtval", bus.mtval, 32'd0);
        chk("rst_mtvec", bus.mtvec_addr, 32'(TB));
        chk("rst_pulses", {30'd0, bus.ret_valid, bus.trap_valid}, 32'd0);
      end
    end
  end

  task automatic cyc(input logic [N-1:0] req, input bit mr, input bit r);
    bus.cause_req = req;
    bus.mret = mr;
    rst = r;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic set_ch(input int ch, input logic [31:0] epc,
                        input logic [31:0] tval);
    bus.cause_epc[ch*XLEN +: XLEN] = epc;
    bus.cause_tval[ch*XLEN +: XLEN] = tval;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc('0, 0, 0);
  endtask

  initial begin
    logic [N-1:0] req;
    bus.cause_req = '0;
    bus.cause_epc = '0;
    bus.cause_tval = '0;
    bus.mret = 1'b0;
    mon_en = 1;
    cyc('0, 0, 1);
    cyc('0, 0, 1);
    idle(2);

    // single fault on channel 1
    set_ch(1, 32'h100, 32'hDEAD);
    for (int i = 0; i < 4; i++) cyc(4'b0010, 0, 0);
    cyc(4'b0010, 1, 0);
    idle(3);

    // simultaneous channels 0 and 2
    set_ch(0, 32'h200, 32'hA0);
    set_ch(2, 32'h300, 32'hA2);
    for (int i = 0; i < 3; i++) cyc(4'b0101, 0, 0);
    cyc(4'b0101, 1, 0);
    for (int i = 0; i < 4; i++) cyc(4'b0000, 0, 0);
    cyc('0, 1, 0);
    idle(3);

    // channel 1 rises inside the handler, edge with mret
    cyc(4'b0001, 0, 0);
    cyc(4'b0001, 0, 0);
    cyc(4'b0011, 0, 0);
    idle(2);
    cyc(4'b1000, 1, 0);
    idle(4);
    cyc('0, 1, 0);
    idle(4);
    cyc('0, 1, 0);
    idle(3);

    // level held 10 cycles: one trap only
    for (int i = 0; i < 10; i++) cyc(4'b0001, i == 4, 0);
    idle(3);

    // mret in idle
    cyc('0, 1, 0);
    cyc('0, 1, 0);
    idle(2);

    // reset mid-handler with pending bits, request held through reset
    cyc(4'b0001, 0, 0);
    cyc(4'b0001, 0, 0);
    cyc(4'b0111, 0, 0);
    cyc(4'b0100, 0, 1);
    cyc(4'b0100, 0, 0);
    idle(3);
    cyc('0, 1, 0);
    idle(3);

    // random traffic
    req = '0;
    for (int i = 0; i < 4000; i++) begin
      for (int c = 0; c < N; c++) begin
        if ($urandom_range(0, 7) == 0) req[c] = ~req[c];
        set_ch(c, $urandom, $urandom);
      end
      cyc(req, $urandom_range(0, 5) == 0, $urandom_range(0, 299) == 0);
    end
    idle(6);
    cyc('0, 1, 0);
    idle(6);

    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain: got %0d left expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
